pc_sequencer: RTL and testbench

Multi-cycle control sequencer for the picoMIPS core. It sits directly upstream of the program counter and drives its `PCincr`/`PCabsbranch`/`PCrelbranch` inputs from the opcode of the current instruction. It stalls the PC for a multi-cycle multiply and for an external-input handshake, evaluates conditional branches against a registered zero flag, and supports a HALT state. Instruction memory is combinational, so the opcode is valid in the same cycle as the PC value that selects it.

---
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/pc_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Control bundle between the picoMIPS instruction decode side and the PC/register-file side.
// The sequencer binds to the slave modport; the surrounding datapath (or a bench) uses master.
interface pc_sequencer_if #(
    parameter int unsigned Osize = 4,
    parameter int unsigned Fsize = 3
);
    logic [Osize-1:0] opcode;
    logic             Zalu;
    logic             ext_valid;
    logic             PCincr;
    logic             PCabsbranch;
    logic             PCrelbranch;
    logic             w;
    logic             imm;
    logic [Fsize-1:0] ALUfunc;
    logic             ext_ack;
    logic             halted;

    modport master (
        output opcode, Zalu, ext_valid,
        input  PCincr, PCabsbranch, PCrelbranch, w, imm, ALUfunc, ext_ack, halted
    );

    modport slave (
        input  opcode, Zalu, ext_valid,
        output PCincr, PCabsbranch, PCrelbranch, w, imm, ALUfunc, ext_ack, halted
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle control sequencer for picoMIPS: drives PC increment/branch controls from the
// current opcode, stalls for MUL and the external-input handshake, and supports HALT.
module pc_sequencer #(
    parameter int unsigned Osize  = 4,
    parameter int unsigned Fsize  = 3,
    parameter int unsigned MULCYC = 2
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = 4;

    localparam logic [Osize-1:0] OP_NOP  = Osize'(0);
    localparam logic [Osize-1:0] OP_ADD  = Osize'(1);
    localparam logic [Osize-1:0] OP_ADDI = Osize'(2);
    localparam logic [Osize-1:0] OP_SUB  = Osize'(3);
    localparam logic [Osize-1:0] OP_MUL  = Osize'(4);
    localparam logic [Osize-1:0] OP_BEQ  = Osize'(5);
    localparam logic [Osize-1:0] OP_BNE  = Osize'(6);
    localparam logic [Osize-1:0] OP_J    = Osize'(7);
    localparam logic [Osize-1:0] OP_IN   = Osize'(8);
    localparam logic [Osize-1:0] OP_HALT = Osize'(9);

    localparam logic [Fsize-1:0] FN_NONE = Fsize'(0);
    localparam logic [Fsize-1:0] FN_ADD  = Fsize'(1);
    localparam logic [Fsize-1:0] FN_SUB  = Fsize'(2);
    localparam logic [Fsize-1:0] FN_MUL  = Fsize'(3);
    localparam logic [Fsize-1:0] FN_IN   = Fsize'(4);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULCYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MULWAIT,
        ST_INWAIT,
        ST_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zq_q, zq_d;
    logic             armed_q, armed_d;

    logic             accept;
    logic             pc_incr, pc_abs, pc_rel;
    logic             wr, imm_sel, ack;
    logic [Fsize-1:0] func;

    // State, stall counter, registered zero flag and handshake arm flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            zq_q    <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zq_q    <= zq_d;
            armed_q <= armed_d;
        end
    end

    // Next-state and Mealy control decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        zq_d    = zq_q;
        armed_d = armed_q;
        pc_incr = 1'b0;
        pc_abs  = 1'b0;
        pc_rel  = 1'b0;
        wr      = 1'b0;
        imm_sel = 1'b0;
        ack     = 1'b0;
        func    = FN_NONE;

        // A level held high from an earlier accept must drop before the next one counts
        accept = bus.ext_valid && armed_q;
        if (!bus.ext_valid) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                case (bus.opcode)
                    OP_NOP: begin
                        pc_incr = 1'b1;
                    end
                    OP_ADD: begin
                        func    = FN_ADD;
                        wr      = 1'b1;
                        pc_incr = 1'b1;
                        zq_d    = bus.Zalu;
                    end
                    OP_ADDI: begin
                        func    = FN_ADD;
                        imm_sel = 1'b1;
                        wr      = 1'b1;
                        pc_incr = 1'b1;
                        zq_d    = bus.Zalu;
                    end
                    OP_SUB: begin
                        func    = FN_SUB;
                        wr      = 1'b1;
                        pc_incr = 1'b1;
                        zq_d    = bus.Zalu;
                    end
                    OP_MUL: begin
                        func    = FN_MUL;
                        cnt_d   = CNT_LOAD;
                        state_d = ST_MULWAIT;
                    end
                    OP_BEQ: begin
                        if (zq_q) pc_rel = 1'b1;
                        else      pc_incr = 1'b1;
                    end
                    OP_BNE: begin
                        if (zq_q) pc_incr = 1'b1;
                        else      pc_rel = 1'b1;
                    end
                    OP_J: begin
                        pc_abs = 1'b1;
                    end
                    OP_IN: begin
                        func = FN_IN;
                        if (accept) begin
                            wr      = 1'b1;
                            ack     = 1'b1;
                            pc_incr = 1'b1;
                            armed_d = 1'b0;
                        end else begin
                            state_d = ST_INWAIT;
                        end
                    end
                    OP_HALT: begin
                        state_d = ST_HALT;
                    end
                    default: begin
                        pc_incr = 1'b1;
                    end
                endcase
            end

            ST_MULWAIT: begin
                func  = FN_MUL;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    wr      = 1'b1;
                    pc_incr = 1'b1;
                    zq_d    = bus.Zalu;
                    state_d = ST_RUN;
                end
            end

            ST_INWAIT: begin
                func = FN_IN;
                if (accept) begin
                    wr      = 1'b1;
                    ack     = 1'b1;
                    pc_incr = 1'b1;
                    armed_d = 1'b0;
                    state_d = ST_RUN;
                end
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Reset silences every control immediately, independent of the clock
    assign bus.PCincr      = !reset && pc_incr;
    assign bus.PCabsbranch = !reset && pc_abs;
    assign bus.PCrelbranch = !reset && pc_rel;
    assign bus.w           = !reset && wr;
    assign bus.imm         = !reset && imm_sel;
    assign bus.ext_ack     = !reset && ack;
    assign bus.ALUfunc     = reset ? FN_NONE : func;
    assign bus.halted      = !reset && (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: each task drives one scenario and compares
// the packed control outputs against hand-derived expectations.
module tb_pc_sequencer;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, ADDI = 4'd2, SUB = 4'd3, MUL = 4'd4,
                           BEQ = 4'd5, BNE = 4'd6, JMP = 4'd7, IN = 4'd8, HLT = 4'd9;

    pc_sequencer_if #(.Osize(4), .Fsize(3)) bus ();

    pc_sequencer #(.Osize(4), .Fsize(3), .MULCYC(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {PCincr, PCabsbranch, PCrelbranch, w, imm, ALUfunc[2:0], ext_ack, halted}
    function automatic logic [9:0] outs();
        return {bus.PCincr, bus.PCabsbranch, bus.PCrelbranch, bus.w, bus.imm,
                bus.ALUfunc, bus.ext_ack, bus.halted};
    endfunction

    function automatic logic [9:0] mk(input logic i, input logic a, input logic r,
                                      input logic wr, input logic im, input logic [2:0] f,
                                      input logic ak, input logic h);
        return {i, a, r, wr, im, f, ak, h};
    endfunction

    task automatic drive(input logic [3:0] op, input logic z, input logic ev);
        bus.opcode    = op;
        bus.Zalu      = z;
        bus.ext_valid = ev;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        drive(ADD, 1'b1, 1'b1);
        got = outs();
        vectors++;
        if (got !== 10'b0) begin
            $display("FAIL reset_add: got %b required %b", got, 10'b0);
            miscompares++;
        end
        drive(IN, 1'b0, 1'b1);
        got = outs();
        vectors++;
        if (got !== 10'b0) begin
            $display("FAIL reset_in: got %b required %b", got, 10'b0);
            miscompares++;
        end
        tick();
        reset = 1'b0;
        drive(NOP, 1'b0, 1'b0);
        got = outs();
        vectors++;
        if (got !== mk(1, 0, 0, 0, 0, 3'd0, 0, 0)) begin
            $display("FAIL reset_release_nop: got %b required %b", got, mk(1, 0, 0, 0, 0, 3'd0, 0, 0));
            miscompares++;
        end
        tick();
    endtask

    task automatic test_branch();
        logic [3:0] op  [10];
        logic       z   [10];
        logic [9:0] exp [10];
        logic [9:0] got;
        op[0] = ADD;  z[0] = 1; exp[0] = mk(1, 0, 0, 1, 0, 3'd1, 0, 0);
        op[1] = BEQ;  z[1] = 0; exp[1] = mk(0, 0, 1, 0, 0, 3'd0, 0, 0);
        op[2] = BNE;  z[2] = 0; exp[2] = mk(1, 0, 0, 0, 0, 3'd0, 0, 0);
        op[3] = SUB;  z[3] = 0; exp[3] = mk(1, 0, 0, 1, 0, 3'd2, 0, 0);
        op[4] = BEQ;  z[4] = 1; exp[4] = mk(1, 0, 0, 0, 0, 3'd0, 0, 0);
        op[5] = BNE;  z[5] = 1; exp[5] = mk(0, 0, 1, 0, 0, 3'd0, 0, 0);
        op[6] = ADDI; z[6] = 1; exp[6] = mk(1, 0, 0, 1, 1, 3'd1, 0, 0);
        op[7] = 4'd12; z[7] = 0; exp[7] = mk(1, 0, 0, 0, 0, 3'd0, 0, 0);
        op[8] = BEQ;  z[8] = 0; exp[8] = mk(0, 0, 1, 0, 0, 3'd0, 0, 0);
        op[9] = 4'd15; z[9] = 0; exp[9] = mk(1, 0, 0, 0, 0, 3'd0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(op[i], z[i], 1'b0);
            got = outs();
            vectors++;
            if (got !== exp[i]) begin
                $display("FAIL branch[%0d] op=%0d: got %b required %b", i, op[i], got, exp[i]);
                miscompares++;
            end
            tick();
        end
    endtask

    task automatic test_mul();
        logic [3:0] op  [5];
        logic       z   [5];
        logic [9:0] exp [5];
        logic [9:0] got;
        op[0] = ADD; z[0] = 0; exp[0] = mk(1, 0, 0, 1, 0, 3'd1, 0, 0);
        op[1] = MUL; z[1] = 0; exp[1] = mk(0, 0, 0, 0, 0, 3'd3, 0, 0);
        op[2] = MUL; z[2] = 0; exp[2] = mk(0, 0, 0, 0, 0, 3'd3, 0, 0);
        op[3] = MUL; z[3] = 1; exp[3] = mk(1, 0, 0, 1, 0, 3'd3, 0, 0);
        op[4] = BEQ; z[4] = 0; exp[4] = mk(0, 0, 1, 0, 0, 3'd0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(op[i], z[i], 1'b0);
            got = outs();
            vectors++;
            if (got !== exp[i]) begin
                $display("FAIL mul[%0d]: got %b required %b", i, got, exp[i]);
                miscompares++;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [9:0] got;
        drive(ADD, 1'b1, 1'b0);
        tick();
        drive(MUL, 1'b0, 1'b0);
        tick();
        got = outs();
        vectors++;
        if (got !== mk(0, 0, 0, 0, 0, 3'd3, 0, 0)) begin
            $display("FAIL midmul_wait: got %b required %b", got, mk(0, 0, 0, 0, 0, 3'd3, 0, 0));
            miscompares++;
        end
        reset = 1'b1;
        #1;
        got = outs();
        vectors++;
        if (got !== 10'b0) begin
            $display("FAIL midmul_reset: got %b required %b", got, 10'b0);
            miscompares++;
        end
        tick();
        reset = 1'b0;
        drive(BEQ, 1'b1, 1'b0);
        got = outs();
        vectors++;
        if (got !== mk(1, 0, 0, 0, 0, 3'd0, 0, 0)) begin
            $display("FAIL midmul_after_beq: got %b required %b", got, mk(1, 0, 0, 0, 0, 3'd0, 0, 0));
            miscompares++;
        end
        tick();
    endtask

    task automatic test_in_wait();
        logic [9:0] got;
        logic [9:0] exp;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                drive(IN, 1'b0, 1'b0);
                exp = mk(0, 0, 0, 0, 0, 3'd4, 0, 0);
            end else if (i == 4) begin
                drive(IN, 1'b0, 1'b1);
                exp = mk(1, 0, 0, 1, 0, 3'd4, 1, 0);
            end else begin
                drive(NOP, 1'b0, 1'b1);
                exp = mk(1, 0, 0, 0, 0, 3'd0, 0, 0);
            end
            got = outs();
            vectors++;
            if (got !== exp) begin
                $display("FAIL in_wait[%0d]: got %b required %b", i, got, exp);
                miscompares++;
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] op  [7];
        logic       ev  [7];
        logic [9:0] exp [7];
        logic [9:0] got;
        op[0] = NOP; ev[0] = 0; exp[0] = mk(1, 0, 0, 0, 0, 3'd0, 0, 0);
        op[1] = IN;  ev[1] = 1; exp[1] = mk(1, 0, 0, 1, 0, 3'd4, 1, 0);
        op[2] = IN;  ev[2] = 1; exp[2] = mk(0, 0, 0, 0, 0, 3'd4, 0, 0);
        op[3] = IN;  ev[3] = 1; exp[3] = mk(0, 0, 0, 0, 0, 3'd4, 0, 0);
        op[4] = IN;  ev[4] = 0; exp[4] = mk(0, 0, 0, 0, 0, 3'd4, 0, 0);
        op[5] = IN;  ev[5] = 1; exp[5] = mk(1, 0, 0, 1, 0, 3'd4, 1, 0);
        op[6] = NOP; ev[6] = 1; exp[6] = mk(1, 0, 0, 0, 0, 3'd0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            drive(op[i], 1'b0, ev[i]);
            got = outs();
            vectors++;
            if (got !== exp[i]) begin
                $display("FAIL back_to_back[%0d]: got %b required %b", i, got, exp[i]);
                miscompares++;
            end
            tick();
        end
        drive(NOP, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_jump_halt();
        logic [9:0] got;
        drive(JMP, 1'b0, 1'b0);
        got = outs();
        vectors++;
        if (got !== mk(0, 1, 0, 0, 0, 3'd0, 0, 0)) begin
            $display("FAIL jump: got %b required %b", got, mk(0, 1, 0, 0, 0, 3'd0, 0, 0));
            miscompares++;
        end
        tick();
        drive(HLT, 1'b0, 1'b0);
        got = outs();
        vectors++;
        if (got !== 10'b0) begin
            $display("FAIL halt_entry: got %b required %b", got, 10'b0);
            miscompares++;
        end
        tick();
        for (int i = 0; i < 22; i++) begin
            drive(4'(i), 1'(i % 3 == 0), 1'(i % 2));
            got = outs();
            vectors++;
            if (got !== mk(0, 0, 0, 0, 0, 3'd0, 0, 1)) begin
                $display("FAIL halted[%0d]: got %b required %b", i, got, mk(0, 0, 0, 0, 0, 3'd0, 0, 1));
                miscompares++;
            end
            tick();
        end
        reset = 1'b1;
        #1;
        got = outs();
        vectors++;
        if (got !== 10'b0) begin
            $display("FAIL halt_reset: got %b required %b", got, 10'b0);
            miscompares++;
        end
        tick();
        reset = 1'b0;
        drive(NOP, 1'b0, 1'b0);
        got = outs();
        vectors++;
        if (got !== mk(1, 0, 0, 0, 0, 3'd0, 0, 0)) begin
            $display("FAIL halt_release: got %b required %b", got, mk(1, 0, 0, 0, 0, 3'd0, 0, 0));
            miscompares++;
        end
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        drive(NOP, 1'b0, 1'b0);
        tick();
        test_reset();
        test_branch();
        test_mul();
        test_reset_mid_mul();
        test_in_wait();
        test_back_to_back();
        test_jump_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
